alu_addsub_seq: RTL and testbench
=================================

ALU_ADDSUB_SEQ -- requirements
Module: alu_addsub_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of CHUNK, minimum 8.
REQ-002 Parameter CHUNK, default 8, bits processed per arithmetic iteration; SHALL divide WIDTH; N = WIDTH/CHUNK.
REQ-003 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 start_in  input  1  request; accepted only in IDLE or DONE.
REQ-006 op_in  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor; other codes behave as add.
REQ-007 A_in, B_in  input  WIDTH  operands, sampled only on the accepting edge.
REQ-008 S_out  output  WIDTH  result, held until the next result is written.
REQ-009 C_out  output  1  carry out of the MSB (for sub: 1 = no borrow); 0 for logic ops.
REQ-010 uerr_out  output  1  unsigned error = C_out XOR sub; 0 for logic ops.
REQ-011 ovf_out  output  1  signed overflow; 0 for logic ops.
REQ-012 zero_out  output  1  1 when S_out == 0.
REQ-013 busy_out  output  1  high while in CALC.
REQ-014 done_out  output  1  single-cycle pulse, high only in DONE.

Function
REQ-015 FSM states IDLE, CALC, DONE; IDLE/DONE + start_in -> CALC; otherwise DONE -> IDLE, IDLE holds.
REQ-016 Accepting edge SHALL latch A_in, B_in, op_in, B' = B_in XOR {WIDTH{sub}}, carry = sub, chunk counter = 0.
REQ-017 Add/sub SHALL process one CHUNK per CALC edge, LSB chunk first, rippling carry through a carry register; after chunk N-1 -> DONE.
REQ-018 Add/sub latency SHALL be N edges from accepting edge to DONE entry (4 for defaults); logic ops SHALL compute the full word on the first CALC edge and enter DONE (latency 1).
REQ-019 ovf_out SHALL equal carry into MSB XOR carry out of MSB for add/sub.
REQ-020 start_in during CALC SHALL be ignored with no effect on the operation in flight.
REQ-021 start_in in DONE SHALL be accepted (back-to-back), done_out still pulses that cycle.
REQ-022 S_out, C_out, uerr_out, ovf_out, zero_out SHALL update only on entry to DONE, so intermediate chunks never appear at outputs.
REQ-023 Operand changes after the accepting edge SHALL not affect the result.

Reset
REQ-024 rst_in high at an edge SHALL force IDLE, counter 0, carry 0, S_out 0, C_out 0, uerr_out 0, ovf_out 0, zero_out 1, busy_out 0, done_out 0.
REQ-025 Reset SHALL take priority over start_in; reset during CALC aborts the operation, no done_out pulse.

Configuration
REQ-026 Macro ALU_ADDSUB_SAT_EN: when defined, signed add/sub with ovf_out=1 SHALL write S_out saturated (0x7FF..F if result sign 1, 0x800..0 if result sign 0); ovf_out still 1; logic ops unaffected.
REQ-027 Without ALU_ADDSUB_SAT_EN, S_out SHALL be the wrapped WIDTH-bit result; no saturation logic present.

Verification (WIDTH=32, CHUNK=8)
REQ-028 add 0xFFFFFFFF + 0x00000001 -> done_out 4 cycles after accept, S=0, C=1, uerr=1, ovf=0, zero=1.
REQ-029 sub 5 - 7 -> S=0xFFFFFFFE, C=0, uerr=1, ovf=0, zero=0; sub 7 - 5 -> S=2, C=1, uerr=0.
REQ-030 add 0x7FFFFFFF + 1 -> ovf=1; S=0x80000000 without macro, 0x7FFFFFFF with ALU_ADDSUB_SAT_EN.
REQ-031 xor 0xF0F0F0F0 ^ 0xFFFF0000 -> done_out 1 cycle after accept, S=0x0F0FF0F0, C=0, ovf=0.
REQ-032 start add 1+1, pulse start_in (3+3) during CALC, then assert rst_in at CALC edge 2 of a second op -> first result S=2 only; after reset all outputs at REQ-024 values, no done_out.

Source files
------------

// File: rtl/alu_addsub_seq.sv
// -----------------------------------------------------------------------------
// alu_addsub_seq
//
// Sequential add/sub/logic unit. Add and subtract are carried out CHUNK bits
// per clock, least-significant chunk first, with the carry held in a register
// between chunks, so a WIDTH-bit add costs WIDTH/CHUNK cycles but only needs a
// CHUNK-bit adder. Bitwise ops (and/or/xor) finish on the first CALC cycle.
//
// Operands and opcode are captured on the accepting edge; the input pins are
// don't-care after that. All result flags are written together on entry to
// DONE, so partial chunk sums never reach the outputs.
//
// Optional feature (compile-time macro):
//   ALU_ADDSUB_SAT_EN - add/sub results that overflow as signed values are
//                       clamped to the most positive / most negative value.
//                       Without it the wrapped WIDTH-bit result is returned.
//
// Parameters:
//   WIDTH  operand/result width, multiple of CHUNK, at least 8
//   CHUNK  bits handled per add/sub iteration (at least 2)
//
// Ports:
//   clk_in    clock, rising edge
//   rst_in    synchronous active-high reset
//   start_in  request, honoured only in IDLE or DONE
//   op_in     000 add, 001 sub, 010 and, 011 or, 100 xor, others add
//   A_in      operand A
//   B_in      operand B
//   S_out     result, held until the next result is written
//   C_out     carry out of MSB (sub: 1 = no borrow), 0 for logic ops
//   uerr_out  unsigned error (C_out xor sub), 0 for logic ops
//   ovf_out   signed overflow, 0 for logic ops
//   zero_out  S_out == 0
//   busy_out  high while calculating
//   done_out  one-cycle pulse while in DONE
// -----------------------------------------------------------------------------
module alu_addsub_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [2:0]       op_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] S_out,
    output logic             C_out,
    output logic             uerr_out,
    output logic             ovf_out,
    output logic             zero_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(N - 1);

    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_t;

    state_t state_q;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // already inverted for subtract
    logic [2:0]       op_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q;    // low chunks of the sum built so far

    // Decode of the incoming request
    logic start_sub;

    // Decode of the captured opcode
    logic is_sub;
    logic is_logic;

    // Current chunk datapath
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_cin;
    logic             arith_ovf;
    logic [WIDTH-1:0] arith_word;
    logic [WIDTH-1:0] final_arith;
    logic [WIDTH-1:0] logic_word;
    logic             last_step;

    // Values written to the outputs on entry to DONE
    logic [WIDTH-1:0] res_word;
    logic             res_c;
    logic             res_uerr;
    logic             res_ovf;

    always_comb begin
        start_sub = (op_in == OP_SUB);
        is_sub    = (op_q == OP_SUB);
        is_logic  = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_XOR);

        a_chunk   = a_q[cnt_q*CHUNK +: CHUNK];
        b_chunk   = b_q[cnt_q*CHUNK +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

        // sum bit = a ^ b ^ cin, so the carry into the top bit falls out of the
        // sum without a second adder. Only meaningful on the last chunk.
        msb_cin   = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
        arith_ovf = msb_cin ^ chunk_sum[CHUNK];

        arith_word = acc_q;
        arith_word[cnt_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];

`ifdef ALU_ADDSUB_SAT_EN
        // Wrapped sign 1 means the true result was too positive, and vice versa
        if (arith_ovf) begin
            if (arith_word[WIDTH-1]) begin
                final_arith = {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                final_arith = {1'b1, {(WIDTH-1){1'b0}}};
            end
        end else begin
            final_arith = arith_word;
        end
`else
        final_arith = arith_word;
`endif

        unique case (op_q)
            OP_AND:  logic_word = a_q & b_q;
            OP_OR:   logic_word = a_q | b_q;
            OP_XOR:  logic_word = a_q ^ b_q;
            default: logic_word = '0;
        endcase

        last_step = is_logic || (cnt_q == LAST_CHUNK);

        if (is_logic) begin
            res_word = logic_word;
            res_c    = 1'b0;
            res_uerr = 1'b0;
            res_ovf  = 1'b0;
        end else begin
            res_word = final_arith;
            res_c    = chunk_sum[CHUNK];
            res_uerr = chunk_sum[CHUNK] ^ is_sub;
            res_ovf  = arith_ovf;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            S_out    <= '0;
            C_out    <= 1'b0;
            uerr_out <= 1'b0;
            ovf_out  <= 1'b0;
            zero_out <= 1'b1;
            busy_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_out <= 1'b0;
                    if (start_in) begin
                        state_q  <= StCalc;
                        busy_out <= 1'b1;
                        a_q      <= A_in;
                        b_q      <= B_in ^ {WIDTH{start_sub}};
                        op_q     <= op_in;
                        carry_q  <= start_sub;   // +1 completes two's complement
                        cnt_q    <= '0;
                        acc_q    <= '0;
                    end else begin
                        state_q  <= StIdle;
                        busy_out <= 1'b0;
                    end
                end
                StCalc: begin
                    if (last_step) begin
                        state_q  <= StDone;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                        S_out    <= res_word;
                        C_out    <= res_c;
                        uerr_out <= res_uerr;
                        ovf_out  <= res_ovf;
                        zero_out <= (res_word == '0);
                    end else begin
                        acc_q   <= arith_word;
                        carry_q <= chunk_sum[CHUNK];
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    busy_out <= 1'b0;
                    done_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_addsub_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_addsub_seq
//
// Bench for alu_addsub_seq (WIDTH=32, CHUNK=8). A behavioural model computes
// each result with plain 33-bit arithmetic and tracks when it must appear
// (4 cycles after accept for add/sub, 1 for logic ops); a compare process
// checks every DUT output against that model each cycle. Directed cases with
// literal expectations pin the model, then a long randomized run follows.
// -----------------------------------------------------------------------------
module tb_alu_addsub_seq;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CHUNK = 8;

    logic             clk_in;
    logic             rst_in;
    logic             start_in;
    logic [2:0]       op_in;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic [WIDTH-1:0] S_out;
    logic             C_out;
    logic             uerr_out;
    logic             ovf_out;
    logic             zero_out;
    logic             busy_out;
    logic             done_out;

    alu_addsub_seq #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .start_in(start_in),
        .op_in   (op_in),
        .A_in    (A_in),
        .B_in    (B_in),
        .S_out   (S_out),
        .C_out   (C_out),
        .uerr_out(uerr_out),
        .ovf_out (ovf_out),
        .zero_out(zero_out),
        .busy_out(busy_out),
        .done_out(done_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        uerr;
        logic        ovf;
        logic        zero;
        int          lat;
    } res_t;

    function automatic res_t model_op(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        res_t        r;
        logic [32:0] sum;
        logic        sub;
        sub = (op == 3'd1);
        r.c = 1'b0; r.uerr = 1'b0; r.ovf = 1'b0; r.lat = 1;
        case (op)
            3'd2: r.s = a & b;
            3'd3: r.s = a | b;
            3'd4: r.s = a ^ b;
            default: begin
                if (sub) sum = {1'b0, a} - {1'b0, b};
                else     sum = {1'b0, a} + {1'b0, b};
                r.s    = sum[31:0];
                // carry out is 1 for sub exactly when there is no borrow
                r.c    = sub ? (a >= b) : sum[32];
                r.uerr = r.c ^ sub;
                if (sub) r.ovf = (a[31] != b[31]) && (r.s[31] != a[31]);
                else     r.ovf = (a[31] == b[31]) && (r.s[31] != a[31]);
`ifdef ALU_ADDSUB_SAT_EN
                if (r.ovf) r.s = r.s[31] ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
                r.lat = int'(WIDTH / CHUNK);
            end
        endcase
        r.zero = (r.s == 32'd0);
        return r;
    endfunction

    logic [31:0] m_s = '0;
    logic        m_c = 0, m_uerr = 0, m_ovf = 0, m_zero = 1, m_busy = 0, m_done = 0;
    int          m_left = 0;
    res_t        m_pend;

    always @(posedge clk_in) begin
        if (rst_in) begin
            m_s = '0; m_c = 0; m_uerr = 0; m_ovf = 0; m_zero = 1;
            m_busy = 0; m_done = 0; m_left = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1;
                m_s = m_pend.s; m_c = m_pend.c; m_uerr = m_pend.uerr;
                m_ovf = m_pend.ovf; m_zero = m_pend.zero;
            end
        end else begin
            m_done = 0;
            if (start_in) begin
                m_pend = model_op(op_in, A_in, B_in);
                m_left = m_pend.lat;
                m_busy = 1;
            end
        end
    end

    // Compare process: outputs are always defined once reset has been seen
    always @(posedge clk_in) begin
        #2;
        if (chk_en) begin
            check("S_out", S_out, m_s);
            check("C_out", {31'd0, C_out}, {31'd0, m_c});
            check("uerr_out", {31'd0, uerr_out}, {31'd0, m_uerr});
            check("ovf_out", {31'd0, ovf_out}, {31'd0, m_ovf});
            check("zero_out", {31'd0, zero_out}, {31'd0, m_zero});
            check("busy_out", {31'd0, busy_out}, {31'd0, m_busy});
            check("done_out", {31'd0, done_out}, {31'd0, m_done});
        end
    end

    // ---------------- stimulus ----------------
    // Issue one request, scramble inputs after the accept edge, wait for done.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        @(negedge clk_in);
        start_in = 1'b1; op_in = op; A_in = a; B_in = b;
        @(negedge clk_in);
        start_in = 1'b0; op_in = 3'($urandom); A_in = $urandom; B_in = $urandom;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_in);
            #2;
            if (done_out) begin
                lat = k;
                break;
            end
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom % 6)
            0: return 32'hFFFF_FFFF;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom % 8);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int lat;
    int done_seen;

    initial begin
        rst_in = 1'b1; start_in = 1'b0; op_in = '0; A_in = '0; B_in = '0;
        repeat (3) @(negedge clk_in);
        chk_en = 1'b1;
        rst_in = 1'b0;

        // Reset values
        check("rst_S", S_out, 32'd0);
        check("rst_zero", {31'd0, zero_out}, 32'd1);

        // Add with carry out, 4-cycle latency
        do_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, lat);
        check("add_lat", lat, 4);
        check("add_S", S_out, 32'd0);
        check("add_C", {31'd0, C_out}, 32'd1);
        check("add_uerr", {31'd0, uerr_out}, 32'd1);
        check("add_ovf", {31'd0, ovf_out}, 32'd0);
        check("add_zero", {31'd0, zero_out}, 32'd1);

        // Subtract, back-to-back from DONE
        do_op(3'd1, 32'd5, 32'd7, lat);
        check("sub57_S", S_out, 32'hFFFF_FFFE);
        check("sub57_C", {31'd0, C_out}, 32'd0);
        check("sub57_uerr", {31'd0, uerr_out}, 32'd1);
        check("sub57_ovf", {31'd0, ovf_out}, 32'd0);
        check("sub57_zero", {31'd0, zero_out}, 32'd0);
        do_op(3'd1, 32'd7, 32'd5, lat);
        check("sub75_S", S_out, 32'd2);
        check("sub75_C", {31'd0, C_out}, 32'd1);
        check("sub75_uerr", {31'd0, uerr_out}, 32'd0);

        // Signed overflow
        do_op(3'd0, 32'h7FFF_FFFF, 32'd1, lat);
        check("ovf_flag", {31'd0, ovf_out}, 32'd1);
`ifdef ALU_ADDSUB_SAT_EN
        check("ovf_S", S_out, 32'h7FFF_FFFF);
`else
        check("ovf_S", S_out, 32'h8000_0000);
`endif

        // Logic op, 1-cycle latency
        do_op(3'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, lat);
        check("xor_lat", lat, 1);
        check("xor_S", S_out, 32'h0F0F_F0F0);
        check("xor_C", {31'd0, C_out}, 32'd0);
        check("xor_ovf", {31'd0, ovf_out}, 32'd0);

        // start during CALC ignored; then reset aborts a second op
        @(negedge clk_in);
        start_in = 1'b1; op_in = 3'd0; A_in = 32'd1; B_in = 32'd1;
        @(negedge clk_in);                       // accepted
        start_in = 1'b0;
        @(negedge clk_in);                       // after CALC edge 1
        start_in = 1'b1; A_in = 32'd3; B_in = 32'd3;
        @(negedge clk_in);
        start_in = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_in);
            #2;
            if (done_out) begin
                lat = k;
                break;
            end
        end
        check("ign_seen_done", {31'd0, done_out}, 32'd1);
        check("ign_S", S_out, 32'd2);
        @(negedge clk_in);
        start_in = 1'b1; op_in = 3'd0; A_in = 32'd9; B_in = 32'd9;
        @(negedge clk_in);                       // accepted
        start_in = 1'b0;
        @(negedge clk_in);                       // after CALC edge 1
        rst_in = 1'b1;
        @(negedge clk_in);                       // CALC edge 2 saw reset
        rst_in = 1'b0;
        check("abort_S", S_out, 32'd0);
        check("abort_zero", {31'd0, zero_out}, 32'd1);
        check("abort_busy", {31'd0, busy_out}, 32'd0);
        done_seen = 0;
        repeat (8) begin
            @(posedge clk_in);
            #2;
            if (done_out) done_seen++;
        end
        check("abort_no_done", done_seen, 0);

        // Randomized traffic: start pulses in any state, occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_in);
            rst_in   = ($urandom % 300 == 0);
            start_in = ($urandom % 3 == 0);
            op_in    = 3'($urandom_range(0, 7));
            A_in     = rand_word();
            B_in     = rand_word();
        end
        @(negedge clk_in);
        rst_in = 1'b0; start_in = 1'b0;
        repeat (6) @(negedge clk_in);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
